lcd_pixel_fifo: RTL and testbench

Elastic pixel buffer directly upstream of the LCD pixel writer in pipe 7. It accepts 24-bit RGB pixels from the pipe-6 output over a valid/ready handshake and stores them in a first-word-fall-through FIFO. It serves them to the pixel writer over its data_req/data_valid/rgb interface. It also tracks frame position, reports underflows and reports start-of-frame misalignment.

---
 rtl/lcd_pixel_fifo.sv | 126 ++++++++++++
 tb/tb_lcd_pixel_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pixel_fifo.sv
// Elastic FWFT pixel buffer feeding the LCD pixel writer, with frame position
// tracking, underflow counting and start-of-frame misalignment detection.
module lcd_pixel_fifo #(
  parameter int DEPTH   = 16,
  parameter int HOR_PIX = 4,
  parameter int VER_PIX = 2
) (
  input  logic                       clk_12mhz,
  input  logic                       rst,
  input  logic [23:0]                in_rgb,
  input  logic                       in_sof,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       data_req,
  output logic [23:0]                rgb,
  output logic                       data_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                underflow_cnt,
  output logic                       sync_err,
  output logic                       frame_done
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int NPIX = HOR_PIX * VER_PIX;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);

  logic [24:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [24:0]   head_q, head_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [15:0]   unf_q, unf_d;
  logic          sync_q, sync_d, fd_q, fd_d;
  logic          push, pop;

  assign in_ready      = (cnt_q != CW'(DEPTH));
  assign data_valid    = (cnt_q != '0);
  assign rgb           = head_q[23:0];
  assign level         = cnt_q;
  assign underflow_cnt = unf_q;
  assign sync_err      = sync_q;
  assign frame_done    = fd_q;

  always_comb begin
    push = in_valid && in_ready;
    pop  = data_req && data_valid;

    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = wr_q + AW'(push);
      rd_d  = rd_q + AW'(pop);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      // The head register mirrors mem[rd] so rgb never depends on data_req.
      if (push && ((cnt_q - CW'(pop)) == '0))
        head_d = {in_sof, in_rgb};
      else if (pop && (cnt_q > CW'(1)))
        head_d = mem_q[rd_q + AW'(1)];
    end
  end

  always_comb begin
    pix_d  = pix_q;
    sync_d = 1'b0;
    fd_d   = 1'b0;
    if (flush) begin
      pix_d = '0;
    end else if (pop) begin
      if (head_q[24]) begin
        sync_d = (pix_q != '0);
        if (NPIX == 1) begin
          pix_d = '0;
          fd_d  = 1'b1;
        end else begin
          pix_d = PW'(1);
        end
      end else if (pix_q == LAST_PIX) begin
        pix_d = '0;
        fd_d  = 1'b1;
      end else begin
        pix_d = pix_q + PW'(1);
      end
    end
  end

  always_comb begin
    unf_d = unf_q;
    if (data_req && (cnt_q == '0) && (unf_q != 16'hFFFF))
      unf_d = unf_q + 16'd1;
  end

  always_ff @(posedge clk_12mhz) begin
    if (push && !flush)
      mem_q[wr_q] <= {in_sof, in_rgb};
  end

  always_ff @(posedge clk_12mhz or negedge rst) begin
    if (!rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      pix_q  <= '0;
      unf_q  <= '0;
      sync_q <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      pix_q  <= pix_d;
      unf_q  <= unf_d;
      sync_q <= sync_d;
      fd_q   <= fd_d;
    end
  end
endmodule

// File: tb/tb_lcd_pixel_fifo.sv
// Randomized self-checking bench for lcd_pixel_fifo against a queue-based
// behavioural model of the FIFO, frame counter and underflow counter.
module tb_lcd_pixel_fifo;
  localparam int DEPTH = 16;
  localparam int HOR_PIX = 4;
  localparam int VER_PIX = 2;
  localparam int NPIX = HOR_PIX * VER_PIX;

  logic        clk_12mhz = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] in_rgb = '0;
  logic        in_sof = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        data_req = 1'b0;
  logic [23:0] rgb;
  logic        data_valid;
  logic [4:0]  level;
  logic [15:0] underflow_cnt;
  logic        sync_err;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  logic [24:0] mq[$];
  int          m_pix = 0;
  int          m_unf = 0;
  bit          m_sync = 0;
  bit          m_fd = 0;

  lcd_pixel_fifo #(.DEPTH(DEPTH), .HOR_PIX(HOR_PIX), .VER_PIX(VER_PIX)) dut (
    .clk_12mhz(clk_12mhz), .rst(rst), .in_rgb(in_rgb), .in_sof(in_sof),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush), .data_req(data_req),
    .rgb(rgb), .data_valid(data_valid), .level(level), .underflow_cnt(underflow_cnt),
    .sync_err(sync_err), .frame_done(frame_done)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  task automatic mreset();
    mq.delete();
    m_pix = 0; m_unf = 0; m_sync = 0; m_fd = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, land at edge+1.
  task automatic cyc(input logic v, input logic [23:0] d, input logic s,
                     input logic r, input logic f);
    bit pu;
    logic [24:0] e;
    in_valid = v; in_rgb = d; in_sof = s; data_req = r; flush = f;
    @(posedge clk_12mhz);
    m_sync = 0; m_fd = 0;
    if (r && mq.size() == 0 && m_unf != 16'hFFFF) m_unf++;
    if (f) begin
      mq.delete();
      m_pix = 0;
    end else begin
      pu = v && (mq.size() < DEPTH);
      if (r && mq.size() > 0) begin
        e = mq.pop_front();
        if (e[24]) begin
          if (m_pix != 0) m_sync = 1;
          if (NPIX == 1) begin m_pix = 0; m_fd = 1; end
          else m_pix = 1;
        end else if (m_pix == NPIX - 1) begin
          m_pix = 0; m_fd = 1;
        end else m_pix++;
      end
      if (pu) mq.push_back({s, d});
    end
    #1;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %0b want 0", data_valid); end
    checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %0h want 0", rgb); end
    checks++; if (underflow_cnt !== 16'h0 || sync_err !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_status: got unf=%0h se=%0b fd=%0b want 0", underflow_cnt, sync_err, frame_done); end
    #7 rst = 1'b1;
    mreset();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) cyc(1, 24'($urandom), i == 0, 0, 0);
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL mid_fill_level: got %0d want 5", level); end
    #3 rst = 1'b0;
    #1;
    checks++; if (level !== 5'd0 || data_valid !== 1'b0 || in_ready !== 1'b1 || rgb !== 24'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got lvl=%0d dv=%0b rdy=%0b rgb=%0h want 0 0 1 0", level, data_valid, in_ready, rgb); end
    #2 rst = 1'b1;
    mreset();
    cyc(0, 0, 0, 0, 0);
    checks++; if (in_ready !== 1'b1 || level !== 5'd0) begin
      errors++; $display("FAIL mid_release: got rdy=%0b lvl=%0d want 1 0", in_ready, level); end
  endtask

  task automatic test_fill_to_full();
    logic [23:0] exp_px[DEPTH];
    logic [23:0] d;
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      d = 24'($urandom);
      if (i < DEPTH) exp_px[i] = d;
      cyc(1, d, 0, 0, 0);
      checks++; if (level !== 5'((i < DEPTH) ? i + 1 : DEPTH)) begin
        errors++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, (i < DEPTH) ? i + 1 : DEPTH); end
      checks++; if (in_ready !== (i + 1 < DEPTH)) begin
        errors++; $display("FAIL fill_ready[%0d]: got %0b want %0b", i, in_ready, i + 1 < DEPTH); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (data_valid !== 1'b1 || rgb !== exp_px[i]) begin
        errors++; $display("FAIL drain_rgb[%0d]: got dv=%0b rgb=%0h want 1 %0h", i, data_valid, rgb, exp_px[i]); end
      cyc(0, 0, 0, 1, 0);
    end
    checks++; if (data_valid !== 1'b0 || level !== 5'd0) begin
      errors++; $display("FAIL drain_empty: got dv=%0b lvl=%0d want 0 0", data_valid, level); end
  endtask

  task automatic test_full_push_pop();
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 24'(i + 24'h100), 0, 0, 0);
    cyc(1, 24'hBADBAD, 0, 1, 0);
    checks++; if (level !== 5'd15 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_pushpop: got lvl=%0d rdy=%0b want 15 1", level, in_ready); end
    checks++; if (rgb !== 24'h101) begin
      errors++; $display("FAIL full_pushpop_head: got %0h want 101", rgb); end
    while (mq.size() > 0) begin
      checks++; if (rgb !== mq[0][23:0]) begin
        errors++; $display("FAIL full_drain: got %0h want %0h", rgb, mq[0][23:0]); end
      cyc(0, 0, 0, 1, 0);
    end
  endtask

  task automatic test_frame_tracking();
    int fd_n = 0, se_n = 0;
    cyc(0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      cyc(k < 16, 24'($urandom), (k % NPIX) == 0, 1, 0);
      fd_n += frame_done; se_n += sync_err;
      checks++; if (frame_done !== m_fd || sync_err !== m_sync) begin
        errors++; $display("FAIL frame_pulse[%0d]: got fd=%0b se=%0b want %0b %0b", k, frame_done, sync_err, m_fd, m_sync); end
    end
    checks++; if (fd_n != 2 || se_n != 0) begin
      errors++; $display("FAIL frame_counts: got fd=%0d se=%0d want 2 0", fd_n, se_n); end
    fd_n = 0; se_n = 0;
    for (int k = 0; k < 14; k++) begin
      cyc(k < 11, 24'($urandom), (k == 0 || k == 3), 1, 0);
      fd_n += frame_done; se_n += sync_err;
      checks++; if (frame_done !== m_fd || sync_err !== m_sync) begin
        errors++; $display("FAIL misalign_pulse[%0d]: got fd=%0b se=%0b want %0b %0b", k, frame_done, sync_err, m_fd, m_sync); end
    end
    checks++; if (se_n != 1 || fd_n != 1) begin
      errors++; $display("FAIL misalign_counts: got se=%0d fd=%0d want 1 1", se_n, fd_n); end
  endtask

  task automatic test_flush();
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 24'($urandom), 0, 0, 0);
    checks++; if (level !== 5'd6) begin errors++; $display("FAIL flush_pre_level: got %0d want 6", level); end
    cyc(1, 24'h123456, 0, 1, 1);
    checks++; if (level !== 5'd0 || data_valid !== 1'b0) begin
      errors++; $display("FAIL flush_level: got lvl=%0d dv=%0b want 0 0", level, data_valid); end
    checks++; if (sync_err !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL flush_pulses: got se=%0b fd=%0b want 0 0", sync_err, frame_done); end
    cyc(0, 0, 0, 0, 0);
    checks++; if (level !== 5'd0 || data_valid !== 1'b0) begin
      errors++; $display("FAIL flush_discard: got lvl=%0d dv=%0b want 0 0", level, data_valid); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 5) == 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
      checks++; if (level !== 5'(mq.size()) || data_valid !== (mq.size() > 0) || in_ready !== (mq.size() < DEPTH)) begin
        errors++; $display("FAIL rand_occ[%0d]: got lvl=%0d dv=%0b rdy=%0b want lvl=%0d", k, level, data_valid, in_ready, mq.size()); end
      if (mq.size() > 0) begin
        checks++; if (rgb !== mq[0][23:0]) begin
          errors++; $display("FAIL rand_rgb[%0d]: got %0h want %0h", k, rgb, mq[0][23:0]); end
      end
      checks++; if (sync_err !== m_sync || frame_done !== m_fd || underflow_cnt !== 16'(m_unf)) begin
        errors++; $display("FAIL rand_status[%0d]: got se=%0b fd=%0b unf=%0h want %0b %0b %0h", k, sync_err, frame_done, underflow_cnt, m_sync, m_fd, m_unf); end
    end
  endtask

  task automatic test_underflow();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    mreset();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    checks++; if (underflow_cnt !== 16'd3) begin errors++; $display("FAIL unf_3: got %0d want 3", underflow_cnt); end
    cyc(0, 0, 0, 0, 1);
    checks++; if (underflow_cnt !== 16'd3) begin errors++; $display("FAIL unf_flush: got %0d want 3", underflow_cnt); end
    for (int i = 0; i < 65531; i++) cyc(0, 0, 0, 1, 0);
    checks++; if (underflow_cnt !== 16'hFFFE) begin errors++; $display("FAIL unf_fffe: got %0h want fffe", underflow_cnt); end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    checks++; if (underflow_cnt !== 16'hFFFF) begin errors++; $display("FAIL unf_sat: got %0h want ffff", underflow_cnt); end
    cyc(0, 0, 0, 1, 1);
    checks++; if (underflow_cnt !== 16'hFFFF) begin errors++; $display("FAIL unf_sat_flush: got %0h want ffff", underflow_cnt); end
  endtask

  initial begin
    #3;
    test_reset();
    test_reset_midstream();
    test_fill_to_full();
    test_full_push_pop();
    test_frame_tracking();
    test_flush();
    test_random();
    test_underflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
